// File: rtl/nibble_to_bit_fifo.sv
// Single-clock asymmetric FIFO: nibble-wide write port, bit-serial read port.
// The registered RAM read stage is also the output register, so a stall just holds it.
module nibble_to_bit_fifo #(
  parameter int NIBBLE_ADDR_W = 12,
  parameter bit LSB_FIRST     = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic                     rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [NIBBLE_ADDR_W+2:0] level,
  output logic                     full,
  output logic                     empty
);

  localparam int LVL_W = NIBBLE_ADDR_W + 3;
  localparam int PTR_W = NIBBLE_ADDR_W + 2;
  localparam int DEPTH = 1 << NIBBLE_ADDR_W;
  localparam logic [LVL_W-1:0] CAP_BITS = LVL_W'(4) << NIBBLE_ADDR_W;
  localparam logic [LVL_W-1:0] WR_LIMIT = CAP_BITS - LVL_W'(4);

  logic [3:0]               mem_q [DEPTH];
  logic [NIBBLE_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic                     rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     wr_ready_q, wr_ready_d;
  logic                     full_q, full_d;
  logic                     empty_q, empty_d;

  logic                     wr_fire_s;
  logic                     rd_fire_s;
  logic                     fetch_s;
  logic [LVL_W-1:0]         unfetched_s;

  function automatic logic [1:0] bit_sel(input logic [1:0] offset);
    logic [1:0] sel;
    if (LSB_FIRST) begin
      sel = offset;
    end else begin
      sel = 2'd3 - offset;
    end
    return sel;
  endfunction

  // Handshakes; bits still in RAM exclude the one held in the output register.
  always_comb begin
    wr_fire_s   = wr_valid & wr_ready_q;
    rd_fire_s   = rd_valid_q & rd_ready;
    unfetched_s = level_q - LVL_W'(rd_valid_q);
    fetch_s     = (unfetched_s != {LVL_W{1'b0}}) & (~rd_valid_q | rd_ready);
  end

  always_comb begin
    if (wr_fire_s) begin
      wr_ptr_d = wr_ptr_q + NIBBLE_ADDR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Output stage refills in the same cycle it is drained, giving one bit per cycle.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (fetch_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      rd_valid_d = 1'b1;
      rd_data_d  = mem_q[rd_ptr_q[PTR_W-1:2]][bit_sel(rd_ptr_q[1:0])];
    end else if (rd_fire_s) begin
      rd_valid_d = 1'b0;
    end else begin
      rd_valid_d = rd_valid_q;
    end
  end

  always_comb begin
    case ({wr_fire_s, rd_fire_s})
      2'b10:   level_d = level_q + LVL_W'(4);
      2'b01:   level_d = level_q - LVL_W'(1);
      2'b11:   level_d = level_q + LVL_W'(3);
      default: level_d = level_q;
    endcase
    wr_ready_d = (level_d <= WR_LIMIT);
    full_d     = (level_d == CAP_BITS);
    empty_d    = (level_d == {LVL_W{1'b0}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= {NIBBLE_ADDR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      level_q    <= {LVL_W{1'b0}};
      rd_data_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_ready_q <= 1'b1;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_ready_q <= wr_ready_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  // Storage array is intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_fire_s && !reset) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ready = wr_ready_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign level    = level_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: tb/tb_nibble_to_bit_fifo.sv
// Bench for nibble_to_bit_fifo: two instances (LSB-first and MSB-first, 16-bit capacity)
// share stimulus and are compared each cycle against a bit-queue reference model.
module tb_nibble_to_bit_fifo;

  localparam int CAP = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] wr_data;
  logic       wr_valid;
  logic       rd_ready;

  logic       wr_ready_l, rd_data_l, rd_valid_l, full_l, empty_l;
  logic [4:0] level_l;
  logic       wr_ready_m, rd_data_m, rd_valid_m, full_m, empty_m;
  logic [4:0] level_m;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit q_lsb[$];
  bit q_msb[$];
  int acc_total;
  int acc_prev;
  int consumed;

  always #5 clk = ~clk;

  nibble_to_bit_fifo #(.NIBBLE_ADDR_W(2), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready_l), .rd_data(rd_data_l), .rd_valid(rd_valid_l),
    .rd_ready(rd_ready), .level(level_l), .full(full_l), .empty(empty_l)
  );

  nibble_to_bit_fifo #(.NIBBLE_ADDR_W(2), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready_m), .rd_data(rd_data_m), .rd_valid(rd_valid_m),
    .rd_ready(rd_ready), .level(level_m), .full(full_m), .empty(empty_m)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_level();
    return acc_total - consumed;
  endfunction

  function automatic bit exp_valid();
    // A bit is visible two cycles after its nibble was accepted.
    return acc_prev > consumed;
  endfunction

  task automatic check_outputs();
    int  lvl;
    bit  vld;
    lvl = exp_level();
    vld = exp_valid();
    check_val("level_lsb", 32'(level_l), 32'(lvl));
    check_val("level_msb", 32'(level_m), 32'(lvl));
    check_val("full_lsb", 32'(full_l), 32'(lvl == CAP));
    check_val("full_msb", 32'(full_m), 32'(lvl == CAP));
    check_val("empty_lsb", 32'(empty_l), 32'(lvl == 0));
    check_val("empty_msb", 32'(empty_m), 32'(lvl == 0));
    check_val("wr_ready_lsb", 32'(wr_ready_l), 32'(lvl <= CAP - 4));
    check_val("wr_ready_msb", 32'(wr_ready_m), 32'(lvl <= CAP - 4));
    check_val("rd_valid_lsb", 32'(rd_valid_l), 32'(vld));
    check_val("rd_valid_msb", 32'(rd_valid_m), 32'(vld));
    if (vld) begin
      check_val("rd_data_lsb", 32'(rd_data_l), 32'(q_lsb[0]));
      check_val("rd_data_msb", 32'(rd_data_m), 32'(q_msb[0]));
    end
  endtask

  // One clock cycle: check at the falling edge, drive, then advance the model.
  task automatic step(input bit wv, input logic [3:0] wd, input bit rr);
    bit wfire;
    bit rfire;
    check_outputs();
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    wfire = wv && (exp_level() <= CAP - 4);
    rfire = rr && exp_valid();
    @(posedge clk);
    acc_prev = acc_total;
    if (wfire) begin
      for (int i = 0; i < 4; i++) begin
        q_lsb.push_back(wd[i]);
        q_msb.push_back(wd[3-i]);
      end
      acc_total += 4;
    end
    if (rfire) begin
      void'(q_lsb.pop_front());
      void'(q_msb.pop_front());
      consumed++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    wr_data  = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q_lsb.delete();
    q_msb.delete();
    acc_total = 0;
    acc_prev  = 0;
    consumed  = 0;
    check_val("rst_rd_data_lsb", 32'(rd_data_l), 32'd0);
    check_val("rst_rd_data_msb", 32'(rd_data_m), 32'd0);
  endtask

  initial begin
    int pat;
    do_reset();

    // Single nibble 4'hA, then back-to-back 4'h3, 4'hC
    step(1'b1, 4'hA, 1'b1);
    repeat (6) step(1'b0, 4'h0, 1'b1);
    step(1'b1, 4'h3, 1'b1);
    step(1'b1, 4'hC, 1'b1);
    repeat (10) step(1'b0, 4'h0, 1'b1);

    // Fill to capacity with reads held off, then release reads slowly
    for (int i = 0; i < 4; i++) step(1'b1, 4'($urandom), 1'b0);
    step(1'b1, 4'hF, 1'b0);
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0);
    repeat (3) step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0);
    repeat (20) step(1'b0, 4'h0, 1'b1);

    // Backpressure pattern 1,0,0,1 with random writes
    pat = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), (pat == 0) || (pat == 3));
      pat = (pat + 1) % 4;
    end
    repeat (30) step(1'b0, 4'h0, 1'b1);

    // Reset mid-stream with buffered data
    for (int i = 0; i < 12; i++) step(1'b1, 4'($urandom), 1'($urandom_range(0, 1)));
    do_reset();
    step(1'b1, 4'h6, 1'b1);
    repeat (8) step(1'b0, 4'h0, 1'b1);

    // Random concurrent traffic across many pointer wraps
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 1) != 0), 4'($urandom), ($urandom_range(0, 1) != 0));
    end
    repeat (40) step(1'b0, 4'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
